load_regread_stage: RTL

LOAD_REGREAD_STAGE -- requirements
Module: load_regread_stage

---
 rtl/load_regread_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/load_regread_stage.sv
// Load register-read stage: fires load issues into the integer regfile,
// reports finish/replay back to the issue queue and holds one load per port
// in a stage register (S1) until the load pipe accepts it.
// Per-port arrays are flattened into packed vectors, port p at slice
// [p*W +: W]. The info word carries iprs_idx[0] in its low IPR_W bits.
module load_regread_stage #(
  parameter int unsigned INOUTPORT_NUM = 2,
  parameter int unsigned IQ_DEPTH      = 8,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned IPR_W         = 7,
  parameter int unsigned INFO_W        = 32,
  localparam int unsigned IDX_W        = $clog2(IQ_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_stall,
  input  logic                            i_flush,
  input  logic [INOUTPORT_NUM-1:0]        i_can_issue,
  input  logic [INOUTPORT_NUM*IDX_W-1:0]  i_issue_idx,
  input  logic [INOUTPORT_NUM*INFO_W-1:0] i_issue_exeInfo,
  output logic [INOUTPORT_NUM-1:0]        o_rf_req,
  output logic [INOUTPORT_NUM*IPR_W-1:0]  o_rf_addr,
  input  logic [INOUTPORT_NUM-1:0]        i_rf_gnt,
  input  logic [INOUTPORT_NUM*XLEN-1:0]   i_rf_data,
  output logic [INOUTPORT_NUM-1:0]        o_issue_finished_vec,
  output logic [INOUTPORT_NUM-1:0]        o_issue_replay_vec,
  output logic [INOUTPORT_NUM*IDX_W-1:0]  o_feedback_idx,
  output logic [INOUTPORT_NUM-1:0]        o_ld_vld,
  output logic [INOUTPORT_NUM*INFO_W-1:0] o_ld_info,
  output logic [INOUTPORT_NUM*XLEN-1:0]   o_ld_base,
  input  logic [INOUTPORT_NUM-1:0]        i_ld_ready,
  output logic [CNT_W-1:0]                o_replay_cnt
);

  logic [INOUTPORT_NUM-1:0] fire;
  logic [INOUTPORT_NUM-1:0] s1_free;
  logic [INOUTPORT_NUM-1:0] accept;

  logic [INOUTPORT_NUM-1:0] vld_q, vld_d;
  logic [INOUTPORT_NUM-1:0] pend_q, pend_d;
  logic [INFO_W-1:0]        info_q [INOUTPORT_NUM];
  logic [INFO_W-1:0]        info_d [INOUTPORT_NUM];
  logic [XLEN-1:0]          data_q [INOUTPORT_NUM];
  logic [XLEN-1:0]          data_d [INOUTPORT_NUM];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_sum;

  // Issue handshake: fire, S1 availability and acceptance per port.
  always_comb begin
    fire    = '0;
    s1_free = '0;
    accept  = '0;
    for (int p = 0; p < int'(INOUTPORT_NUM); p++) begin
      fire[p]    = i_can_issue[p] & ~i_stall & ~i_flush;
      s1_free[p] = ~vld_q[p] | i_ld_ready[p];
      accept[p]  = fire[p] & i_rf_gnt[p] & s1_free[p];
    end
  end

  // Regfile request and same-cycle feedback to the issue queue.
  always_comb begin
    o_rf_addr = '0;
    for (int p = 0; p < int'(INOUTPORT_NUM); p++) begin
      o_rf_addr[p*IPR_W +: IPR_W] = i_issue_exeInfo[p*INFO_W +: IPR_W];
    end
    o_rf_req             = fire;
    o_issue_finished_vec = accept;
    o_issue_replay_vec   = fire & ~accept;
    o_feedback_idx       = i_issue_idx;
  end

  // S1 next state: flush > refill on accept > drain > capture read data on stall.
  always_comb begin
    vld_d  = vld_q;
    pend_d = pend_q;
    for (int p = 0; p < int'(INOUTPORT_NUM); p++) begin
      info_d[p] = info_q[p];
      data_d[p] = data_q[p];
      if (i_flush) begin
        vld_d[p]  = 1'b0;
        pend_d[p] = 1'b0;
      end else if (accept[p]) begin
        vld_d[p]  = 1'b1;
        pend_d[p] = 1'b1;
        info_d[p] = i_issue_exeInfo[p*INFO_W +: INFO_W];
      end else if (vld_q[p] && i_ld_ready[p]) begin
        vld_d[p]  = 1'b0;
        pend_d[p] = 1'b0;
      end else if (vld_q[p] && pend_q[p]) begin
        // Read data is only on the bus this cycle, so park it in S1.
        data_d[p] = i_rf_data[p*XLEN +: XLEN];
        pend_d[p] = 1'b0;
      end
    end
  end

  // Saturating replay counter next state.
  always_comb begin
    cnt_sum = {1'b0, cnt_q};
    for (int p = 0; p < int'(INOUTPORT_NUM); p++) begin
      cnt_sum = cnt_sum + {{CNT_W{1'b0}}, o_issue_replay_vec[p]};
    end
    cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload registers; meaningless while the matching vld is low.
  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(INOUTPORT_NUM); p++) begin
      info_q[p] <= info_d[p];
      data_q[p] <= data_d[p];
    end
  end

  // Load pipe outputs: base bypasses the regfile bus while still pending.
  always_comb begin
    o_ld_info = '0;
    o_ld_base = '0;
    for (int p = 0; p < int'(INOUTPORT_NUM); p++) begin
      o_ld_info[p*INFO_W +: INFO_W] = info_q[p];
      o_ld_base[p*XLEN +: XLEN] = pend_q[p] ? i_rf_data[p*XLEN +: XLEN] : data_q[p];
    end
    o_ld_vld     = vld_q;
    o_replay_cnt = cnt_q;
  end

endmodule
